multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle MIPS control FSM; drives the ALU operation code and datapath selects, consumes ALU zero flag.
//  Sequences fetch/decode/execute/memory/writeback per instruction, with wait states on a memory-ready handshake.
//  Sits between instruction register (opcode/funct) and the shared-ALU datapath; one ALU op issued per cycle.
// PARAMETERS
//  none (encodings fixed: ALU op SUB=0001 OR=0010 ADD=0011 LUI=0100 SLL=0101 SRL=0110 AND=0111 NOR=1000)
// PORTS
//  clk              in   1  system clock, all state on rising edge
//  reset            in   1  asynchronous, active-low reset
//  opcode_i         in   6  IR[31:26]
//  funct_i          in   6  IR[5:0]
//  zero_i           in   1  ALU zero flag, same cycle as alu_operation_o
//  mem_ready_i      in   1  memory completes current read/write this cycle
//  alu_operation_o  out  4  ALU op code (encodings above)
//  alu_src_a_o      out  1  0=PC, 1=reg A
//  alu_src_b_o      out  2  0=reg B, 1=const 4, 2=extended imm, 3=sign-ext imm<<2
//  imm_zext_o       out  1  1=zero-extend imm (andi/ori), 0=sign-extend
//  iord_o           out  1  memory address: 0=PC, 1=ALUOut
//  mem_read_o       out  1  memory read request
//  mem_write_o      out  1  memory write request
//  ir_write_o       out  1  load IR
//  reg_dst_o        out  1  write reg: 0=rt, 1=rd
//  mem_to_reg_o     out  1  write data: 0=ALUOut, 1=MDR
//  reg_write_o      out  1  register file write enable
//  pc_source_o      out  2  0=ALU result, 1=ALUOut, 2=jump target
//  pc_write_o       out  1  PC load enable
//  illegal_o        out  1  one-cycle pulse: unsupported opcode/funct decoded
// BEHAVIOUR
//  - Reset (reset=0, async): state=RST; every output 0 (alu_operation_o=0000). Release -> FETCH next edge.
//  - Outputs Moore-decoded from state, except strobes gated by mem_ready_i/zero_i as noted; unlisted outputs 0.
//  - FETCH: mem_read=1, iord=0, ALU ADD, src_a=0, src_b=1, pc_source=0; ir_write=pc_write=mem_ready_i.
//    Stay while mem_ready_i=0; ->DECODE when 1.
//  - DECODE: ALU ADD, src_a=0, src_b=3 (branch target into ALUOut). Next by opcode:
//    0x00 R-type funct 0x20 ADD,0x22 SUB,0x24 AND,0x25 OR,0x27 NOR,0x00 SLL,0x02 SRL -> R_EXEC;
//    0x08 addi,0x0C andi,0x0D ori,0x0F lui -> I_EXEC; 0x23 lw,0x2B sw -> MEM_ADDR;
//    0x04 beq,0x05 bne -> BRANCH; 0x02 j -> JUMP; anything else -> ILLEGAL.
//  - R_EXEC: src_a=1, src_b=0, op from funct -> R_WB. R_WB: reg_dst=1, reg_write=1 -> FETCH.
//  - I_EXEC: src_a=1, src_b=2; addi ADD, andi AND(zext), ori OR(zext), lui LUI -> I_WB.
//    I_WB: reg_dst=0, reg_write=1 -> FETCH. imm_zext_o=1 in I_EXEC for andi/ori only.
//  - MEM_ADDR: src_a=1, src_b=2, ADD, sign-ext -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: mem_read=1, iord=1; wait on mem_ready_i -> MEM_WB. MEM_WB: mem_to_reg=1, reg_write=1 -> FETCH.
//  - MEM_WR: mem_write=1, iord=1; wait on mem_ready_i -> FETCH.
//  - BRANCH: src_a=1, src_b=0, SUB, pc_source=1; pc_write = zero_i (beq) / ~zero_i (bne), combinational -> FETCH.
//  - JUMP: pc_source=2, pc_write=1 -> FETCH. ILLEGAL: illegal_o=1, no PC/reg/mem write -> FETCH.
//  - Cycle counts (mem_ready_i=1 always): R/I-type 4, lw 5, sw 4, beq/bne 3, j 3, illegal 3.
//  - Opcode/funct sampled only in DECODE; changes elsewhere ignored. mem strobes held stable through waits.
//  - Reset mid-instruction: immediate abort to RST, all outputs 0, no partial write completes.
//  - Unreachable state encodings -> FETCH next edge, outputs 0.
// TESTING
//  - Reset low mid-MEM_WR -> mem_write_o=0 immediately; release -> 1 cycle all 0, then FETCH mem_read_o=1.
//  - add (op 0x00,funct 0x20), mem_ready_i=1 -> ops ADD,ADD,ADD(0011); reg_write_o=1,reg_dst_o=1 cycle 4 only.
//  - lw with mem_ready_i low 2 cycles in MEM_RD -> mem_read_o,iord_o held 3 cycles; reg_write_o once, mem_to_reg_o=1.
//  - beq zero_i=1 -> BRANCH op=0001, pc_write_o=1, pc_source_o=1; bne zero_i=1 -> pc_write_o=0.
//  - ori (0x0D) -> I_EXEC op=0010, imm_zext_o=1; lui (0x0F) -> op=0100; addi -> op=0011, imm_zext_o=0.
//  - opcode 0x3F or R-type funct 0x2A -> illegal_o pulse 1 cycle, no reg_write/mem_write/pc_write, back to FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS sequencer and its shared-ALU datapath.
// The controller is the master: it consumes IR fields and status flags and drives every select/strobe.
interface multicycle_control_if;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic [3:0] alu_operation_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic       imm_zext_o;
    logic       iord_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic [1:0] pc_source_o;
    logic       pc_write_o;
    logic       illegal_o;

    modport master (
        input  opcode_i, funct_i, zero_i, mem_ready_i,
        output alu_operation_o, alu_src_a_o, alu_src_b_o, imm_zext_o, iord_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, pc_source_o, pc_write_o, illegal_o
    );

    modport slave (
        output opcode_i, funct_i, zero_i, mem_ready_i,
        input  alu_operation_o, alu_src_a_o, alu_src_b_o, imm_zext_o, iord_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, pc_source_o, pc_write_o, illegal_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory-ready wait states; outputs are Moore-decoded from state, gated by mem_ready_i/zero_i.
module multicycle_control (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        bus
);
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1000;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_R_WB     = 4'd4,
        S_I_EXEC   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    logic [5:0] funct_q;

    function automatic logic [3:0] alu_from_funct(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h27:   return ALU_NOR;
            6'h00:   return ALU_SLL;
            6'h02:   return ALU_SRL;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic logic [3:0] alu_from_imm_op(input logic [5:0] op);
        case (op)
            6'h08:   return ALU_ADD;
            6'h0C:   return ALU_AND;
            6'h0D:   return ALU_OR;
            6'h0F:   return ALU_LUI;
            default: return ALU_NONE;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // IR fields are captured in DECODE only, so later IR activity cannot disturb execution
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q <= 6'h00;
            funct_q  <= 6'h00;
        end else if (state_q == S_DECODE) begin
            opcode_q <= bus.opcode_i;
            funct_q  <= bus.funct_i;
        end else begin
            opcode_q <= opcode_q;
            funct_q  <= funct_q;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode_i)
                    6'h00: begin
                        if (alu_from_funct(bus.funct_i) != ALU_NONE) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_ILLEGAL;
                        end
                    end
                    6'h08, 6'h0C, 6'h0D, 6'h0F: state_d = S_I_EXEC;
                    6'h23, 6'h2B:               state_d = S_MEM_ADDR;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
                    default:                    state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; unreachable encodings fall to the all-zero defaults
    always_comb begin
        bus.alu_operation_o = ALU_NONE;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'd0;
        bus.imm_zext_o      = 1'b0;
        bus.iord_o          = 1'b0;
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.pc_source_o     = 2'd0;
        bus.pc_write_o      = 1'b0;
        bus.illegal_o       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read_o      = 1'b1;
                bus.alu_operation_o = ALU_ADD;
                bus.alu_src_b_o     = 2'd1;
                bus.ir_write_o      = bus.mem_ready_i;
                bus.pc_write_o      = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.alu_operation_o = ALU_ADD;
                bus.alu_src_b_o     = 2'd3;
            end
            S_R_EXEC: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_operation_o = alu_from_funct(funct_q);
            end
            S_R_WB: begin
                bus.reg_dst_o   = 1'b1;
                bus.reg_write_o = 1'b1;
            end
            S_I_EXEC: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_src_b_o     = 2'd2;
                bus.alu_operation_o = alu_from_imm_op(opcode_q);
                bus.imm_zext_o      = (opcode_q == 6'h0C) || (opcode_q == 6'h0D);
            end
            S_I_WB:     bus.reg_write_o = 1'b1;
            S_MEM_ADDR: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_src_b_o     = 2'd2;
                bus.alu_operation_o = ALU_ADD;
            end
            S_MEM_RD: begin
                bus.mem_read_o = 1'b1;
                bus.iord_o     = 1'b1;
            end
            S_MEM_WB: begin
                bus.mem_to_reg_o = 1'b1;
                bus.reg_write_o  = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write_o = 1'b1;
                bus.iord_o      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_operation_o = ALU_SUB;
                bus.pc_source_o     = 2'd1;
                bus.pc_write_o      = (opcode_q == 6'h04) ? bus.zero_i : ~bus.zero_i;
            end
            S_JUMP: begin
                bus.pc_source_o = 2'd2;
                bus.pc_write_o  = 1'b1;
            end
            S_ILLEGAL:  bus.illegal_o = 1'b1;
            default:    bus.illegal_o = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into its list of
// execution steps and every cycle's full control word is compared against the step's expected word.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       zx;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic [1:0] ps;
        logic       pw;
        logic       ill;
    } ctl_t;

    localparam int K_FETCH = 0, K_DECODE = 1, K_RX = 2, K_RWB = 3, K_IX = 4, K_IWB = 5,
                   K_MA = 6, K_MRD = 7, K_MWB = 8, K_MWR = 9, K_BR = 10, K_J = 11, K_IL = 12;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_ILL = 6;

    function automatic logic [3:0] op_of_funct(input logic [5:0] f);
        case (f)
            6'h20: return 4'b0011;   // add
            6'h22: return 4'b0001;   // sub
            6'h24: return 4'b0111;   // and
            6'h25: return 4'b0010;   // or
            6'h27: return 4'b1000;   // nor
            6'h00: return 4'b0101;   // sll
            6'h02: return 4'b0110;   // srl
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                      return (op_of_funct(fn) != 4'b0000) ? C_R : C_ILL;
            6'h08, 6'h0C, 6'h0D, 6'h0F: return C_I;
            6'h23:                      return C_LW;
            6'h2B:                      return C_SW;
            6'h04, 6'h05:               return C_BR;
            6'h02:                      return C_J;
            default:                    return C_ILL;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input int kind, input logic mr, input logic z,
                                        input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (kind)
            K_FETCH:  begin c.mrd = 1'b1; c.alu = 4'b0011; c.sb = 2'd1; c.irw = mr; c.pw = mr; end
            K_DECODE: begin c.alu = 4'b0011; c.sb = 2'd3; end
            K_RX:     begin c.sa = 1'b1; c.alu = op_of_funct(fn); end
            K_RWB:    begin c.rdst = 1'b1; c.rw = 1'b1; end
            K_IX: begin
                c.sa = 1'b1; c.sb = 2'd2;
                c.alu = (op == 6'h08) ? 4'b0011 : (op == 6'h0C) ? 4'b0111 :
                        (op == 6'h0D) ? 4'b0010 : 4'b0100;
                c.zx = (op == 6'h0C) || (op == 6'h0D);
            end
            K_IWB:    c.rw = 1'b1;
            K_MA:     begin c.sa = 1'b1; c.sb = 2'd2; c.alu = 4'b0011; end
            K_MRD:    begin c.mrd = 1'b1; c.iord = 1'b1; end
            K_MWB:    begin c.m2r = 1'b1; c.rw = 1'b1; end
            K_MWR:    begin c.mwr = 1'b1; c.iord = 1'b1; end
            K_BR:     begin c.sa = 1'b1; c.alu = 4'b0001; c.ps = 2'd1; c.pw = (op == 6'h04) ? z : ~z; end
            K_J:      begin c.ps = 2'd2; c.pw = 1'b1; end
            K_IL:     c.ill = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c = {bus.alu_operation_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.imm_zext_o, bus.iord_o,
             bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
             bus.reg_write_o, bus.pc_source_o, bus.pc_write_o, bus.illegal_o};
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        ctl_t got;
        got = observed();
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle of one step: IR fields are only meaningful during DECODE, random elsewhere
    task automatic step(input int kind, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic z, input string tag);
        #1;
        bus.mem_ready_i = mr;
        bus.zero_i      = z;
        bus.opcode_i    = (kind == K_DECODE) ? op : 6'($urandom);
        bus.funct_i     = (kind == K_DECODE) ? fn : 6'($urandom);
        #3;
        check($sformatf("%s.k%0d", tag, kind), expect_ctl(kind, mr, z, op, fn));
        @(posedge clk);
    endtask

    // Starts right at the edge that enters FETCH; ends at the edge that re-enters FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stalls,
                             input int zsel, input string tag);
        int   steps[$];
        int   n;
        logic z;
        steps = {K_FETCH, K_DECODE};
        case (classify(op, fn))
            C_R:     begin steps.push_back(K_RX); steps.push_back(K_RWB); end
            C_I:     begin steps.push_back(K_IX); steps.push_back(K_IWB); end
            C_LW:    begin steps.push_back(K_MA); steps.push_back(K_MRD); steps.push_back(K_MWB); end
            C_SW:    begin steps.push_back(K_MA); steps.push_back(K_MWR); end
            C_BR:    steps.push_back(K_BR);
            C_J:     steps.push_back(K_J);
            default: steps.push_back(K_IL);
        endcase
        foreach (steps[i]) begin
            z = (zsel == 1) ? 1'b1 : (zsel == 2) ? 1'b0 : 1'($urandom);
            if (steps[i] == K_FETCH || steps[i] == K_MRD || steps[i] == K_MWR) begin
                n = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
                for (int s = 0; s < n; s++) step(steps[i], op, fn, 1'b0, z, tag);
                step(steps[i], op, fn, 1'b1, z, tag);
            end else begin
                step(steps[i], op, fn, 1'($urandom), z, tag);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops[11];
        logic [5:0] fns[8];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h2A};

        reset           = 1'b0;
        bus.opcode_i    = 6'h00;
        bus.funct_i     = 6'h00;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b1;
        #2 check("reset_hold", '0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #2 check("reset_release", '0);
        @(posedge clk);

        // Directed cases
        run_instr(6'h00, 6'h20, 0, 0, "add");
        run_instr(6'h23, 6'h00, 2, 0, "lw_stall2");
        run_instr(6'h04, 6'h00, 0, 1, "beq_z1");
        run_instr(6'h05, 6'h00, 0, 1, "bne_z1");
        run_instr(6'h05, 6'h00, 0, 2, "bne_z0");
        run_instr(6'h0D, 6'h00, 0, 0, "ori");
        run_instr(6'h0F, 6'h00, 0, 0, "lui");
        run_instr(6'h08, 6'h00, 0, 0, "addi");
        run_instr(6'h0C, 6'h00, 1, 0, "andi");
        run_instr(6'h3F, 6'h00, 0, 0, "ill_op");
        run_instr(6'h00, 6'h2A, 0, 0, "ill_funct");
        run_instr(6'h02, 6'h00, 0, 0, "jump");
        run_instr(6'h2B, 6'h00, 1, 0, "sw");

        // Reset asserted while a store is waiting on memory
        step(K_FETCH, 6'h2B, 6'h00, 1'b1, 1'b0, "swrst");
        step(K_DECODE, 6'h2B, 6'h00, 1'b1, 1'b0, "swrst");
        step(K_MA, 6'h2B, 6'h00, 1'b1, 1'b0, "swrst");
        #1 bus.mem_ready_i = 1'b0;
        #2 check("mid_memwr", expect_ctl(K_MWR, 1'b0, 1'b0, 6'h2B, 6'h00));
        #1 reset = 1'b0;
        #1 check("abort_memwr", '0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.mem_ready_i = 1'b1;
        #3 check("abort_release", '0);
        @(posedge clk);

        // Randomized instruction stream with random memory stalls
        for (int i = 0; i < 250; i++) begin
            op = ops[$urandom_range(0, 10)];
            fn = fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run_instr(op, fn, -1, 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
